bus_responder: RTL and testbench
================================

# bus_responder

Memory/IO responder on the 8085 external multiplexed bus: the slave end of the machine cycles (M1, R1, R2, W1, W2) issued by the CPU's timing/decode logic. It latches the address on ALE, decodes memory or IO space, inserts a programmable number of wait states through READY, drives read data onto the AD bus, and commits write data. It holds an internal RAM and one IO port, and sits between the CPU core's bus pins and the system testbench/top level.

## Interface
- MEM_AW, 10: RAM address width; the RAM holds 2^MEM_AW bytes.
- MEM_BASE, 16'h0000: memory window base; aligned to 2^MEM_AW.
- IO_ADDR, 8'hF0: port number of the single IO register.
- WAIT_STATES, 1: wait states per selected read or write, 0..7.

- clk  in  1  bus clock (CPU CLK out); all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- ale  in  1  address latch enable.
- ad_in  in  8  multiplexed AD7..AD0 as driven by the CPU.
- a_hi  in  8  A15..A8.
- iom_n  in  1  1 = IO cycle, 0 = memory cycle.
- s1, s0  in  1 each  status: 11 opcode fetch, 10 read, 01 write, 00 halt.
- rd_n, wr_n  in  1 each  read and write strobes, active-low.
- io_in  in  8  value returned on IO reads of IO_ADDR.
- ad_out  out  8  read data.
- ad_oe  out  1  AD output enable; the responder drives the bus only while this is 1.
- ready  out  1  READY to the CPU; 0 requests a wait state.
- io_out  out  8  last value written to IO_ADDR.
- fetch_done  out  1  1-cycle pulse when an opcode fetch read completes.
- bus_err  out  1  1-cycle pulse on a protocol violation.

## Operation
- FSM states: IDLE, ADDR, WAIT, DATA, WRHOLD.
- ALE sampled 1, any state:
  - Latch addr = {a_hi, ad_in}, iom_n, s1, s0.
  - Go to ADDR.
  - If this occurs outside IDLE or ADDR, abort the current cycle, pulse bus_err, and discard any pending write.
- Select logic:
  - mem_sel = !iom_n and addr[15:MEM_AW] == MEM_BASE[15:MEM_AW].
  - io_sel = iom_n and addr[7:0] == IO_ADDR.
  - When neither is set, the cycle is ignored: ready stays 1, ad_oe stays 0, FSM returns to IDLE when a strobe rises.
- ADDR, rd_n sampled 0 while selected:
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT if the count is > 0, otherwise go to DATA.
  - Register ad_out from mem[addr[MEM_AW-1:0]] or io_in. The read value is captured at this strobe edge.
- ADDR, wr_n sampled 0 while selected: same counter handling, then go to WRHOLD instead of DATA.
- WAIT:
  - ready = 0; decrement the counter each cycle.
  - At zero, go to DATA (read) or WRHOLD (write).
- DATA:
  - ad_oe = 1.
  - On rd_n sampled 1, clear ad_oe and go to IDLE.
  - Pulse fetch_done on that edge if {s1,s0} == 11.
- WRHOLD:
  - Register ad_in every cycle while wr_n = 0.
  - On wr_n sampled 1, write the last registered byte to RAM or io_out, then go to IDLE.
- rd_n and wr_n both 0 in any state: pulse bus_err, treat as unselected, return to IDLE.
- Halt status (s1s0 = 00) with no strobe: stay in ADDR, no response.
- Reset:
  - Outputs: ad_out = 0, ad_oe = 0, ready = 1, io_out = 0, fetch_done = 0, bus_err = 0.
  - FSM goes to IDLE; a pending write is dropped.
  - RAM contents are not cleared.

## Timing
- Let K = the first cycle in which the strobe is sampled low.
- Read, W = WAIT_STATES:
  - ready = 0 in cycles K+1..K+W.
  - ready = 1 and ad_oe = 1 with valid ad_out from K+W+1.
  - ad_oe = 0 in the cycle after rd_n is sampled high.
- Write:
  - ready = 0 in K+1..K+W.
  - Commit happens in the cycle after wr_n is sampled high.
  - A read of the same address issued in the next bus cycle returns the new value.
- W = 0: ready never drops.
- ALE to strobe: at least 1 cycle. A strobe sampled in the same cycle as ALE is ignored.
- ready is driven combinationally from the state register only; no input-to-ready combinational path.

## Test plan
- Memory read, WAIT_STATES=1, mem[0x0012]=0xA5, addr 0x0012:
  - ready low exactly 1 cycle after rd_n falls.
  - ad_oe=1 with ad_out=0xA5 until 1 cycle after rd_n rises.
- Opcode fetch (s1s0=11) at 0x03FF with WAIT_STATES=0:
  - ready stays 1 and data is valid the cycle after rd_n falls.
  - fetch_done pulses once.
- Memory write 0x5C to 0x0100, then read back: 0x5C returned. IO write 0x3E to port 0xF0: io_out=0x3E.
- Unselected cycles:
  - Memory access to 0x8000 with MEM_AW=10 produces no ad_oe and no ready drop.
  - IO read of port 0x10 produces no response.
- Protocol errors:
  - rd_n and wr_n both low: bus_err pulse, ad_oe stays 0.
  - ALE during WAIT: cycle aborted, new address latched, bus_err pulse.
- reset asserted in WRHOLD:
  - No RAM write occurs; all outputs return to their reset values next cycle.
  - Previously written RAM data is still readable.

Source files
------------

// File: rtl/bus_responder.sv
// bus_responder: slave side of the 8085 multiplexed bus. Latches the address
// on ALE, decodes one RAM window and one IO port, stretches selected cycles
// with a fixed number of READY wait states, returns read data and commits
// write data when the write strobe is released.
module bus_responder #(
  parameter int unsigned MEM_AW      = 10,
  parameter logic [15:0] MEM_BASE    = 16'h0000,
  parameter logic [7:0]  IO_ADDR     = 8'hF0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ale,
  input  logic [7:0] ad_in,
  input  logic [7:0] a_hi,
  input  logic       iom_n,
  input  logic       s1,
  input  logic       s0,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] io_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ready,
  output logic [7:0] io_out,
  output logic       fetch_done,
  output logic       bus_err
);

  localparam int unsigned MEM_DEPTH = 32'd1 << MEM_AW;
  localparam logic [2:0]  WAIT_LD   = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRHOLD = 3'd4
  } state_t;

  state_t      state_r, state_nx_s;
  logic [15:0] addr_r;
  logic        iom_r;
  logic [1:0]  stat_r;
  logic [2:0]  cnt_r;
  logic        is_wr_r;
  logic [7:0]  wdata_r;
  logic        unsel_seen_r;
  logic        both_low_r;
  logic [7:0]  ad_out_r;
  logic [7:0]  io_out_r;
  logic        fetch_done_r;
  logic        bus_err_r;
  logic [7:0]  mem_r [0:MEM_DEPTH-1];

  logic mem_sel_s, io_sel_s, sel_s, both_low_s;
  logic rd_start_s, wr_start_s, commit_s, fetch_end_s, abort_s;

  assign mem_sel_s  = !iom_r && (addr_r[15:MEM_AW] == MEM_BASE[15:MEM_AW]);
  assign io_sel_s   = iom_r && (addr_r[7:0] == IO_ADDR);
  assign sel_s      = mem_sel_s || io_sel_s;
  assign both_low_s = !rd_n && !wr_n;

  // Next-state and per-cycle control decode; ALE always restarts a cycle.
  always_comb begin
    state_nx_s  = state_r;
    rd_start_s  = 1'b0;
    wr_start_s  = 1'b0;
    commit_s    = 1'b0;
    fetch_end_s = 1'b0;
    abort_s     = 1'b0;
    if (ale) begin
      state_nx_s = ST_ADDR;
      abort_s    = (state_r != ST_IDLE) && (state_r != ST_ADDR);
    end else if (both_low_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_ADDR: begin
          if (sel_s && !rd_n) begin
            rd_start_s = 1'b1;
            state_nx_s = (WAIT_LD != 3'd0) ? ST_WAIT : ST_DATA;
          end else if (sel_s && !wr_n) begin
            wr_start_s = 1'b1;
            state_nx_s = (WAIT_LD != 3'd0) ? ST_WAIT : ST_WRHOLD;
          end else if (!sel_s && unsel_seen_r && rd_n && wr_n) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_ADDR;
          end
        end
        ST_WAIT: begin
          if (cnt_r <= 3'd1) begin
            state_nx_s = is_wr_r ? ST_WRHOLD : ST_DATA;
          end else begin
            state_nx_s = ST_WAIT;
          end
        end
        ST_DATA: begin
          if (rd_n) begin
            state_nx_s  = ST_IDLE;
            fetch_end_s = (stat_r == 2'b11);
          end else begin
            state_nx_s = ST_DATA;
          end
        end
        ST_WRHOLD: begin
          if (wr_n) begin
            state_nx_s = ST_IDLE;
            commit_s   = 1'b1;
          end else begin
            state_nx_s = ST_WRHOLD;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register, address/status latch, wait counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= 16'h0000;
      iom_r        <= 1'b0;
      stat_r       <= 2'b00;
      cnt_r        <= 3'd0;
      is_wr_r      <= 1'b0;
      wdata_r      <= 8'h00;
      unsel_seen_r <= 1'b0;
      both_low_r   <= 1'b0;
      ad_out_r     <= 8'h00;
      io_out_r     <= 8'h00;
      fetch_done_r <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (ale) begin
        addr_r <= {a_hi, ad_in};
        iom_r  <= iom_n;
        stat_r <= {s1, s0};
      end
      if (rd_start_s || wr_start_s) begin
        cnt_r   <= WAIT_LD;
        is_wr_r <= wr_start_s;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 3'd1;
      end
      // Read data is captured at the strobe edge, not when ad_oe rises.
      if (rd_start_s) begin
        ad_out_r <= mem_sel_s ? mem_r[addr_r[MEM_AW-1:0]] : io_in;
      end
      // Keep the most recent byte seen while the write strobe is low.
      if (!wr_n && (wr_start_s || state_r == ST_WAIT || state_r == ST_WRHOLD)) begin
        wdata_r <= ad_in;
      end
      if (ale) begin
        unsel_seen_r <= 1'b0;
      end else if (state_r == ST_ADDR && !sel_s && (!rd_n || !wr_n)) begin
        unsel_seen_r <= 1'b1;
      end else if (state_nx_s != ST_ADDR) begin
        unsel_seen_r <= 1'b0;
      end
      if (commit_s && io_sel_s) begin
        io_out_r <= wdata_r;
      end
      both_low_r   <= both_low_s;
      fetch_done_r <= fetch_end_s;
      bus_err_r    <= abort_s || (both_low_s && !both_low_r);
    end
  end

  // RAM write port; contents survive reset, but no commit happens under reset.
  always_ff @(posedge clk) begin
    if (!reset && commit_s && mem_sel_s) begin
      mem_r[addr_r[MEM_AW-1:0]] <= wdata_r;
    end
  end

  assign ready      = (state_r != ST_WAIT);
  assign ad_oe      = (state_r == ST_DATA);
  assign ad_out     = ad_out_r;
  assign io_out     = io_out_r;
  assign fetch_done = fetch_done_r;
  assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: two instances (1 and 0 wait states) share one bus.
// Expected values come from a byte-array memory model and per-cycle timing
// rules relative to the first strobe-low cycle.
module tb_bus_responder;

  localparam int          MEM_AW   = 10;
  localparam logic [15:0] MEM_BASE = 16'h0000;
  localparam logic [7:0]  IO_ADDR  = 8'hF0;

  logic       clk = 1'b0;
  logic       reset, ale, iom_n, s1, s0, rd_n, wr_n;
  logic [7:0] ad_in, a_hi, io_in;
  logic [7:0] ad_out_a, io_out_a, ad_out_b, io_out_b;
  logic       ad_oe_a, ready_a, fetch_done_a, bus_err_a;
  logic       ad_oe_b, ready_b, fetch_done_b, bus_err_b;

  bus_responder #(.MEM_AW(MEM_AW), .MEM_BASE(MEM_BASE), .IO_ADDR(IO_ADDR), .WAIT_STATES(1)) u_dut_a (
    .clk(clk), .reset(reset), .ale(ale), .ad_in(ad_in), .a_hi(a_hi), .iom_n(iom_n),
    .s1(s1), .s0(s0), .rd_n(rd_n), .wr_n(wr_n), .io_in(io_in),
    .ad_out(ad_out_a), .ad_oe(ad_oe_a), .ready(ready_a), .io_out(io_out_a),
    .fetch_done(fetch_done_a), .bus_err(bus_err_a));

  bus_responder #(.MEM_AW(MEM_AW), .MEM_BASE(MEM_BASE), .IO_ADDR(IO_ADDR), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset), .ale(ale), .ad_in(ad_in), .a_hi(a_hi), .iom_n(iom_n),
    .s1(s1), .s0(s0), .rd_n(rd_n), .wr_n(wr_n), .io_in(io_in),
    .ad_out(ad_out_b), .ad_oe(ad_oe_b), .ready(ready_b), .io_out(io_out_b),
    .fetch_done(fetch_done_b), .bus_err(bus_err_b));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [7:0] mem_m   [0:1023];
  bit         known_m [0:1023];
  logic [7:0] io_m;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit mem_sel_f(input logic [15:0] a, input bit io);
    return !io && ((a >> MEM_AW) == (MEM_BASE >> MEM_AW));
  endfunction

  function automatic bit io_sel_f(input logic [15:0] a, input bit io);
    return io && (a[7:0] == IO_ADDR);
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, ".ready.a"}, 8'(ready_a), 8'h01);
    chk({tag, ".ready.b"}, 8'(ready_b), 8'h01);
    chk({tag, ".ad_oe.a"}, 8'(ad_oe_a), 8'h00);
    chk({tag, ".ad_oe.b"}, 8'(ad_oe_b), 8'h00);
    chk({tag, ".ad_out.a"}, ad_out_a, 8'h00);
    chk({tag, ".ad_out.b"}, ad_out_b, 8'h00);
    chk({tag, ".io_out.a"}, io_out_a, 8'h00);
    chk({tag, ".io_out.b"}, io_out_b, 8'h00);
    chk({tag, ".fetch.a"}, 8'(fetch_done_a), 8'h00);
    chk({tag, ".fetch.b"}, 8'(fetch_done_b), 8'h00);
    chk({tag, ".err.a"}, 8'(bus_err_a), 8'h00);
    chk({tag, ".err.b"}, 8'(bus_err_b), 8'h00);
  endtask

  // j = cycles since the first strobe-low cycle; hold = strobe-low length.
  task automatic check_both(input string tag, input int j, input int hold, input bit sel,
                            input bit is_rd, input logic [1:0] st, input bit dknown,
                            input logic [7:0] data);
    for (int d = 0; d < 2; d++) begin
      int w;
      bit er, eo, ef;
      string t;
      w  = (d == 0) ? 1 : 0;
      er = !(sel && j >= 1 && j <= w);
      eo = sel && is_rd && j >= w + 1 && j <= hold;
      ef = sel && is_rd && st == 2'b11 && j == hold + 1;
      t  = $sformatf("%s.w%0d.j%0d", tag, w, j);
      chk({t, ".ready"}, 8'((d == 0) ? ready_a : ready_b), 8'(er));
      chk({t, ".ad_oe"}, 8'((d == 0) ? ad_oe_a : ad_oe_b), 8'(eo));
      chk({t, ".fetch"}, 8'((d == 0) ? fetch_done_a : fetch_done_b), 8'(ef));
      chk({t, ".err"}, 8'((d == 0) ? bus_err_a : bus_err_b), 8'h00);
      if (eo && dknown) begin
        chk({t, ".ad_out"}, (d == 0) ? ad_out_a : ad_out_b, data);
      end
    end
  endtask

  task automatic addr_phase(input logic [15:0] a, input bit io, input logic [1:0] st);
    ale = 1'b1; a_hi = a[15:8]; ad_in = a[7:0]; iom_n = io; {s1, s0} = st;
    rd_n = 1'b1; wr_n = 1'b1;
    tick();
    ale = 1'b0;
  endtask

  task automatic read_phase(input string tag, input logic [15:0] a, input bit io,
                            input logic [1:0] st, input int hold);
    bit sel, dknown;
    logic [7:0] data;
    io_in  = 8'($urandom);
    sel    = mem_sel_f(a, io) || io_sel_f(a, io);
    dknown = io ? 1'b1 : known_m[a[9:0]];
    data   = io ? io_in : mem_m[a[9:0]];
    rd_n   = 1'b0;
    for (int j = 1; j <= hold + 1; j++) begin
      tick();
      check_both(tag, j, hold, sel, 1'b1, st, dknown, data);
      rd_n = (j < hold) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic write_phase(input string tag, input logic [15:0] a, input bit io,
                             input int hold, input logic [7:0] data);
    bit sel;
    sel   = mem_sel_f(a, io) || io_sel_f(a, io);
    wr_n  = 1'b0;
    ad_in = (hold > 1) ? 8'($urandom) : data;
    for (int j = 1; j <= hold + 1; j++) begin
      tick();
      check_both(tag, j, hold, sel, 1'b0, 2'b01, 1'b0, 8'h00);
      wr_n  = (j < hold) ? 1'b0 : 1'b1;
      ad_in = (j < hold - 1) ? 8'($urandom) : data;
    end
    if (mem_sel_f(a, io)) begin
      mem_m[a[9:0]]   = data;
      known_m[a[9:0]] = 1'b1;
    end
    if (io_sel_f(a, io)) begin
      io_m = data;
    end
    chk({tag, ".io_out.a"}, io_out_a, io_m);
    chk({tag, ".io_out.b"}, io_out_b, io_m);
  endtask

  initial begin
    logic [15:0] ra;
    bit          rio;
    int          op, hold;
    for (int i = 0; i < 1024; i++) known_m[i] = 1'b0;
    io_m  = 8'h00;
    reset = 1'b1; ale = 1'b0; ad_in = 8'h00; a_hi = 8'h00; iom_n = 1'b0;
    s1 = 1'b0; s0 = 1'b0; rd_n = 1'b1; wr_n = 1'b1; io_in = 8'h00;
    tick();
    tick();
    check_reset("reset");
    reset = 1'b0;
    tick();

    // Memory read with wait state, after seeding the byte.
    addr_phase(16'h0012, 1'b0, 2'b01); write_phase("wr12", 16'h0012, 1'b0, 2, 8'hA5);
    addr_phase(16'h0012, 1'b0, 2'b10); read_phase("rd12", 16'h0012, 1'b0, 2'b10, 3);

    // Opcode fetch at the top of the window.
    addr_phase(16'h03FF, 1'b0, 2'b01); write_phase("wr3ff", 16'h03FF, 1'b0, 2, 8'h3C);
    addr_phase(16'h03FF, 1'b0, 2'b11); read_phase("fetch3ff", 16'h03FF, 1'b0, 2'b11, 2);

    // Write then read back; IO port write.
    addr_phase(16'h0100, 1'b0, 2'b01); write_phase("wr100", 16'h0100, 1'b0, 3, 8'h5C);
    addr_phase(16'h0100, 1'b0, 2'b10); read_phase("rd100", 16'h0100, 1'b0, 2'b10, 2);
    addr_phase(16'h00F0, 1'b1, 2'b01); write_phase("iowr", 16'h00F0, 1'b1, 2, 8'h3E);

    // Unselected memory and IO cycles.
    addr_phase(16'h8000, 1'b0, 2'b10); read_phase("unsel8000", 16'h8000, 1'b0, 2'b10, 2);
    addr_phase(16'h1010, 1'b1, 2'b10); read_phase("unselio10", 16'h1010, 1'b1, 2'b10, 2);

    // Both strobes low.
    addr_phase(16'h0012, 1'b0, 2'b10);
    rd_n = 1'b0; wr_n = 1'b0;
    tick();
    chk("bothlow.err.a", 8'(bus_err_a), 8'h01);
    chk("bothlow.err.b", 8'(bus_err_b), 8'h01);
    chk("bothlow.oe.a", 8'(ad_oe_a), 8'h00);
    chk("bothlow.oe.b", 8'(ad_oe_b), 8'h00);
    rd_n = 1'b1; wr_n = 1'b1;
    tick();
    chk("bothlow2.err.a", 8'(bus_err_a), 8'h00);
    chk("bothlow2.oe.a", 8'(ad_oe_a), 8'h00);

    // ALE arriving mid-cycle aborts it and latches the new address.
    addr_phase(16'h0012, 1'b0, 2'b10);
    rd_n = 1'b0;
    tick();
    chk("abort.wait.ready.a", 8'(ready_a), 8'h00);
    ale = 1'b1; a_hi = 8'h01; ad_in = 8'h00; iom_n = 1'b0; {s1, s0} = 2'b10; rd_n = 1'b1;
    tick();
    chk("abort.err.a", 8'(bus_err_a), 8'h01);
    chk("abort.err.b", 8'(bus_err_b), 8'h01);
    chk("abort.ready.a", 8'(ready_a), 8'h01);
    chk("abort.oe.b", 8'(ad_oe_b), 8'h00);
    ale = 1'b0;
    read_phase("abortrd", 16'h0100, 1'b0, 2'b10, 2);

    // Reset while holding a write in WRHOLD.
    addr_phase(16'h0100, 1'b0, 2'b01);
    wr_n = 1'b0; ad_in = 8'h77;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset("rstwr");
    wr_n = 1'b1;
    tick();
    reset = 1'b0;
    io_m = 8'h00;
    tick();
    addr_phase(16'h0100, 1'b0, 2'b10); read_phase("rstwr.rd", 16'h0100, 1'b0, 2'b10, 2);

    // Randomized mix of reads, fetches and writes.
    for (int n = 0; n < 60; n++) begin
      op   = $urandom_range(0, 2);
      hold = $urandom_range(2, 4);
      case ($urandom_range(0, 3))
        0: begin ra = 16'($urandom); rio = 1'b0; end
        3: begin
          ra  = {8'($urandom), ($urandom_range(0, 1) == 0) ? IO_ADDR : 8'($urandom)};
          rio = 1'b1;
        end
        default: begin ra = {12'h000, 4'($urandom)}; rio = 1'b0; end
      endcase
      if (op == 0) begin
        addr_phase(ra, rio, 2'b01);
        write_phase($sformatf("rnd%0d.wr", n), ra, rio, hold, 8'($urandom));
      end else begin
        addr_phase(ra, rio, (op == 1) ? 2'b10 : 2'b11);
        read_phase($sformatf("rnd%0d.rd", n), ra, rio, (op == 1) ? 2'b10 : 2'b11, hold);
      end
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
